axi_ad7124_frame_buf: RTL and testbench

AXI_AD7124_FRAME_BUF -- requirements
Module: axi_ad7124_frame_buf

---
 rtl/axi_ad7124_pkg.sv | 10 +
 rtl/axi_ad7124_pp_ram.sv | 29 ++
 rtl/axi_ad7124_frame_buf.sv | 114 +++++++++++
 tb/tb_axi_ad7124_frame_buf.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/axi_ad7124_pkg.sv
// axi_ad7124_pkg: hold-state type and frame-size legality check shared by the frame buffer.
package axi_ad7124_pkg;

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_e;

    function automatic bit frame_bytes_ok(input int n);
        return (n % 4 == 0) && (n >= 4) && (n <= 1024);
    endfunction

endpackage

// File: rtl/axi_ad7124_pp_ram.sv
// axi_ad7124_pp_ram: simple dual-port 32-bit RAM, one write port and one registered read port.
module axi_ad7124_pp_ram #(
    parameter int DEPTH = 16,
    localparam int RAW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [31:0]    wdata,
    input  logic           re,
    input  logic [RAW-1:0] raddr,
    output logic [31:0]    rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // only the read register is reset; array contents stay undefined
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/axi_ad7124_frame_buf.sv
// axi_ad7124_frame_buf: packs SPI offload bytes into 32-bit words and double-buffers
// whole conversion frames for the host, dropping frames while the held one is unreleased.
module axi_ad7124_frame_buf import axi_ad7124_pkg::*; #(
    parameter int FRAME_BYTES = 32,
    parameter int CNT_W = 16,
    localparam int WORDS = FRAME_BYTES / 4,
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [31:0]      rd_data,
    output logic             frame_ready,
    input  logic             frame_release,
    output logic             drdy,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int BW = $clog2(FRAME_BYTES);
    localparam int RAW = $clog2(2 * WORDS);

    if (!frame_bytes_ok(FRAME_BYTES)) begin : g_bad_frame_bytes
        $error("FRAME_BYTES must be a multiple of 4 in 4..1024");
    end

    logic [BW-1:0]      idx_q, idx_d, idx_cur;
    logic [2:0][7:0]    word_q, word_d, word_cur;
    logic               fb_q, fb_d;
    hold_e              hold_q, hold_d;
    logic               drdy_q, drdy_d, ovf_q, ovf_d, rd_oob_q, rd_oob_d, s_ready_q;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               acc, last, we, re;
    logic [RAW-1:0]     widx, waddr, raddr;
    logic [31:0]        ram_rdata;

    always_comb begin
        acc = s_valid && s_ready_q;
        idx_cur = trigger ? '0 : idx_q;
        word_cur = trigger ? '0 : word_q;
        last = acc && (idx_cur == BW'(FRAME_BYTES - 1));
        we = acc && (idx_cur[1:0] == 2'd3);
        idx_d = acc ? (last ? '0 : idx_cur + 1'b1) : idx_cur;
        word_d = word_cur;
        if (acc && !we) word_d[idx_cur[1:0]] = s_data;
        widx = RAW'(idx_cur >> 2);
        waddr = fb_q ? RAW'(WORDS) + widx : widx;
        // hold bank is the one not being filled, taken before this cycle's commit
        raddr = fb_q ? RAW'(rd_addr) : RAW'(WORDS) + RAW'(rd_addr);
        rd_oob_d = rd_en ? (32'(rd_addr) >= WORDS) : rd_oob_q;
        re = rd_en && !rd_oob_d;
        fb_d = fb_q;
        hold_d = hold_q;
        drdy_d = 1'b0;
        ovf_d = 1'b0;
        drop_d = drop_q;
        if (last && (hold_q == HOLD_EMPTY || frame_release)) begin
            fb_d = !fb_q;
            hold_d = HOLD_FULL;
            drdy_d = 1'b1;
        end else if (last) begin
            ovf_d = 1'b1;
            drop_d = drop_q + CNT_W'(drop_q != '1);
        end else if (frame_release) begin
            hold_d = HOLD_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            word_q <= '0;
            fb_q <= 1'b0;
            hold_q <= HOLD_EMPTY;
            drdy_q <= 1'b0;
            ovf_q <= 1'b0;
            drop_q <= '0;
            rd_oob_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            word_q <= word_d;
            fb_q <= fb_d;
            hold_q <= hold_d;
            drdy_q <= drdy_d;
            ovf_q <= ovf_d;
            drop_q <= drop_d;
            rd_oob_q <= rd_oob_d;
            s_ready_q <= 1'b1;
        end
    end

    axi_ad7124_pp_ram #(.DEPTH(2 * WORDS)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata ({s_data, word_cur}),
        .re    (re),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    assign rd_data = rd_oob_q ? '0 : ram_rdata;
    assign s_ready = s_ready_q;
    assign frame_ready = (hold_q == HOLD_FULL);
    assign drdy = drdy_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_axi_ad7124_frame_buf.sv
// tb_axi_ad7124_frame_buf: directed checks of packing, hold/drop behaviour, trigger and reset.
module tb_axi_ad7124_frame_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        rd_en = 1'b0;
    logic [0:0]  rd_addr = '0;
    logic        frame_release = 1'b0;
    logic        s_ready, frame_ready, drdy, overflow;
    logic [31:0] rd_data;
    logic [15:0] drop_cnt;
    logic        s_ready2, frame_ready2, drdy2, overflow2;
    logic [31:0] rd_data2;
    logic [1:0]  drop_cnt2;
    logic [31:0] v;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    axi_ad7124_frame_buf #(.FRAME_BYTES(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .trigger(trigger), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_ready(frame_ready), .frame_release(frame_release), .drdy(drdy),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    axi_ad7124_frame_buf #(.FRAME_BYTES(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .trigger(trigger), .s_valid(s_valid), .s_ready(s_ready2),
        .s_data(s_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
        .frame_ready(frame_ready2), .frame_release(frame_release), .drdy(drdy2),
        .overflow(overflow2), .drop_cnt(drop_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic rel_last, input logic rd_last);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data = base + 8'(i);
            frame_release = rel_last && (i == 7);
            rd_en = rd_last && (i == 7);
            rd_addr = '0;
            tick();
        end
        s_valid = 1'b0;
        frame_release = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic rd(input logic a, output logic [31:0] d);
        rd_en = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_frame_ready", 32'(frame_ready), 0);
        chk("rst_drdy", 32'(drdy), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_rd_data", rd_data, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("s_ready_up", 32'(s_ready), 1);

        send_frame(8'h01, 1'b0, 1'b0);
        chk("f1_drdy", 32'(drdy), 1);
        chk("f1_ovf", 32'(overflow), 0);
        chk("f1_ready", 32'(frame_ready), 1);
        tick();
        chk("f1_drdy_one_cycle", 32'(drdy), 0);
        rd(1'b0, v);
        chk("f1_word0", v, 32'h04030201);
        rd(1'b1, v);
        chk("f1_word1", v, 32'h08070605);
        tick();
        chk("rd_hold", rd_data, 32'h08070605);

        send_frame(8'h11, 1'b0, 1'b0);
        chk("drop1_ovf", 32'(overflow), 1);
        chk("drop1_drdy", 32'(drdy), 0);
        send_frame(8'h21, 1'b0, 1'b0);
        chk("drop2_ovf", 32'(overflow), 1);
        chk("drop2_cnt", 32'(drop_cnt), 2);
        chk("drop2_ready", 32'(frame_ready), 1);
        rd(1'b0, v);
        chk("drop2_held", v, 32'h04030201);

        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        chk("release_empty", 32'(frame_ready), 0);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = 8'h55 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        send_frame(8'hA0, 1'b0, 1'b0);
        chk("trig_drdy", 32'(drdy), 1);
        chk("trig_ovf", 32'(overflow), 0);
        chk("trig_drop", 32'(drop_cnt), 2);
        rd(1'b0, v);
        chk("trig_word0", v, 32'hA3A2A1A0);
        rd(1'b1, v);
        chk("trig_word1", v, 32'hA7A6A5A4);

        send_frame(8'hB0, 1'b1, 1'b1);
        chk("commit_rd_old", rd_data, 32'hA3A2A1A0);
        chk("coin_drdy", 32'(drdy), 1);
        chk("coin_ovf", 32'(overflow), 0);
        chk("coin_ready", 32'(frame_ready), 1);
        chk("coin_drop", 32'(drop_cnt), 2);
        rd(1'b0, v);
        chk("coin_word0", v, 32'hB3B2B1B0);

        send_frame(8'h31, 1'b0, 1'b0);
        chk("sat3_cnt", 32'(drop_cnt2), 3);
        send_frame(8'h41, 1'b0, 1'b0);
        chk("sat4_cnt", 32'(drop_cnt2), 3);
        send_frame(8'h51, 1'b0, 1'b0);
        chk("sat5_ovf", 32'(overflow2), 1);
        chk("sat5_cnt", 32'(drop_cnt2), 3);
        chk("wide5_cnt", 32'(drop_cnt), 5);

        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = 8'h90 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(frame_ready), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        chk("mid_rst_drop2", 32'(drop_cnt2), 0);
        chk("mid_rst_rd", rd_data, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready", 32'(s_ready), 1);
        send_frame(8'hC0, 1'b0, 1'b0);
        chk("post_rst_drdy", 32'(drdy), 1);
        chk("post_rst_ovf", 32'(overflow), 0);
        chk("post_rst_ready", 32'(frame_ready), 1);
        rd(1'b0, v);
        chk("post_rst_word0", v, 32'hC3C2C1C0);
        rd(1'b1, v);
        chk("post_rst_word1", v, 32'hC7C6C5C4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
